// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [3:0] SL_LB   = 4'b0000;
    localparam logic [3:0] SL_LH   = 4'b0001;
    localparam logic [3:0] SL_LW   = 4'b0010;
    localparam logic [3:0] SL_SB   = 4'b1000;
    localparam logic [3:0] SL_SH   = 4'b1001;
    localparam logic [3:0] SL_SW   = 4'b1010;
    localparam logic [3:0] SL_NONE = 4'b1111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Bytes touched by the access; 0 marks an encoding with no size.
    function automatic logic [2:0] access_size(input logic [2:0] f3);
        logic [2:0] sz;
        sz = 3'd0;
        unique case (1'b1)
            (f3 == F3_B),
            (f3 == F3_BU): sz = 3'd1;
            (f3 == F3_H),
            (f3 == F3_HU): sz = 3'd2;
            (f3 == F3_W):  sz = 3'd4;
            default:       sz = 3'd0;
        endcase
        return sz;
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    function automatic logic [3:0] sl_type(input logic we, input logic [2:0] f3);
        logic [3:0] sl;
        sl = SL_NONE;
        unique case (access_size(f3))
            3'd1:    sl = we ? SL_SB : SL_LB;
            3'd2:    sl = we ? SL_SH : SL_LH;
            3'd4:    sl = we ? SL_SW : SL_LW;
            default: sl = SL_NONE;
        endcase
        return sl;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake between execute stage and load/store unit.
interface lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid,
        output req_we,
        output req_funct3,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_funct3,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err
    );

endinterface

// File: rtl/lsu_extend.sv
// Sign/zero extension of raw memory read data by load funct3.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_raw,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_raw;
        unique case (1'b1)
            (i_funct3 == F3_B):  o_data = {{24{i_raw[7]}}, i_raw[7:0]};
            (i_funct3 == F3_H):  o_data = {{16{i_raw[15]}}, i_raw[15:0]};
            (i_funct3 == F3_BU): o_data = {24'd0, i_raw[7:0]};
            (i_funct3 == F3_HU): o_data = {16'd0, i_raw[15:0]};
            default:             o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, single-cycle memory access,
// registered extended load result or error response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_if.slave        bus,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    output logic [3:0]  mem_SLType,
    input  logic [31:0] mem_RD
);

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rdata;

    logic [2:0]  w_size;
    logic        w_misal;
    logic [32:0] w_end;
    logic        w_oor;
    logic        w_err;
    logic        w_accept;
    logic        w_access;
    logic [31:0] w_ext;

    assign w_size  = access_size(bus.req_funct3);
    assign w_misal = ((w_size == 3'd2) && bus.req_addr[0])
                  || ((w_size == 3'd4) && (bus.req_addr[1:0] != 2'b00));
    // 33-bit sum so addresses near 2^32 cannot wrap into range.
    assign w_end   = {1'b0, bus.req_addr} + {30'd0, w_size};
    assign w_oor   = w_end > 33'(MEM_BYTES);
    assign w_err   = !f3_legal(bus.req_we, bus.req_funct3)
                  || w_misal || w_oor;

    assign w_accept = (r_state == IDLE) && bus.req_valid;
    assign w_access = (r_state == ACCESS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_next = w_err ? RESP : ACCESS;
                end
            end
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_f3    <= 3'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else if (w_accept) begin
            r_we    <= bus.req_we;
            r_f3    <= bus.req_funct3;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_err   <= w_err;
            r_rdata <= 32'd0;
        end else if (w_access && !r_we) begin
            r_rdata <= w_ext;
        end
    end

    lsu_extend u_extend (
        .i_funct3 (r_f3),
        .i_raw    (mem_RD),
        .o_data   (w_ext)
    );

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_rdata = bus.resp_valid ? r_rdata : 32'd0;
    assign bus.resp_err   = bus.resp_valid & r_err;

    // Memory strobes decode from state alone, so reset kills them at once.
    assign mem_A      = w_access ? r_addr : 32'd0;
    assign mem_WD     = w_access ? r_wdata : 32'd0;
    assign mem_WE     = w_access & r_we;
    assign mem_SLType = w_access ? sl_type(r_we, r_f3) : SL_NONE;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-array memory
// and a shadow reference model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [3:0]  mem_SLType;
    logic [31:0] mem_RD;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem    [256] = '{default: 8'h00};
    logic [7:0] shadow [256] = '{default: 8'h00};

    lsu_if u_bus ();

    load_store_unit #(.MEM_BYTES(256)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (u_bus),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_WE     (mem_WE),
        .mem_SLType (mem_SLType),
        .mem_RD     (mem_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    // Byte memory: writes on the edge, reads combinationally, zero-filled.
    always @(posedge clk) begin
        if (mem_WE && mem_A < 32'd256) begin
            case (mem_SLType)
                4'b1000: mem[mem_A[7:0]] <= mem_WD[7:0];
                4'b1001: begin
                    mem[mem_A[7:0]]        <= mem_WD[7:0];
                    mem[mem_A[7:0] + 8'd1] <= mem_WD[15:8];
                end
                4'b1010: begin
                    mem[mem_A[7:0]]        <= mem_WD[7:0];
                    mem[mem_A[7:0] + 8'd1] <= mem_WD[15:8];
                    mem[mem_A[7:0] + 8'd2] <= mem_WD[23:16];
                    mem[mem_A[7:0] + 8'd3] <= mem_WD[31:24];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_RD = 32'd0;
        if (mem_A < 32'd256) begin
            case (mem_SLType)
                4'b0000: mem_RD = {24'd0, mem[mem_A[7:0]]};
                4'b0001: mem_RD = {16'd0, mem[mem_A[7:0] + 8'd1],
                                   mem[mem_A[7:0]]};
                4'b0010: mem_RD = {mem[mem_A[7:0] + 8'd3],
                                   mem[mem_A[7:0] + 8'd2],
                                   mem[mem_A[7:0] + 8'd1],
                                   mem[mem_A[7:0]]};
                default: mem_RD = 32'd0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [2:0] f3);
        int n;
        n = 4;
        if (f3[1:0] == 2'd0) n = 1;
        else if (f3[1:0] == 2'd1) n = 2;
        return n;
    endfunction

    // Reference behaviour from the architectural rules.
    task automatic model(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd);
        logic legal;
        int   n;
        logic [31:0] val;
        if (we) legal = (f3 <= 3'd2);
        else legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        n   = nbytes_of(f3);
        err = !legal || (addr % n != 0) || (longint'(addr) + n > 256);
        rd  = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) shadow[addr + i] = wd[8*i +: 8];
            end else begin
                val = 32'd0;
                for (int i = 0; i < n; i++)
                    val = val + (32'(shadow[addr + i]) << (8 * i));
                if (f3 == 3'd0 && val >= 32'd128) val = val - 32'd256;
                if (f3 == 3'd1 && val >= 32'd32768) val = val - 32'd65536;
                rd = val;
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input string tag, output logic [31:0] got_rd);
        logic        exp_err;
        logic [31:0] exp_rd;
        logic        got;
        logic        got_err;
        int          lat;
        int          we_seen;
        int          n;
        model(we, f3, addr, wd, exp_err, exp_rd);
        @(negedge clk);
        n = 0;
        while (!u_bus.req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(u_bus.req_ready), 32'd1);
        u_bus.req_valid  = 1'b1;
        u_bus.req_we     = we;
        u_bus.req_funct3 = f3;
        u_bus.req_addr   = addr;
        u_bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        u_bus.req_valid = 1'b0;
        got = 1'b0; got_err = 1'b0; got_rd = 32'd0;
        lat = 0; we_seen = 0;
        for (int c = 1; c <= 4 && !got; c++) begin
            @(negedge clk);
            if (mem_WE) we_seen++;
            if (c == 1 && !exp_err) begin
                check({tag, "_memA"}, mem_A, addr);
                check({tag, "_sl"}, 32'(mem_SLType),
                      32'((we ? 8 : 0) + (nbytes_of(f3) == 1 ? 0 :
                          nbytes_of(f3) == 2 ? 1 : 2)));
                if (we) check({tag, "_memWD"}, mem_WD, wd);
            end
            if (u_bus.resp_valid) begin
                got = 1'b1; lat = c;
                got_err = u_bus.resp_err;
                got_rd = u_bus.resp_rdata;
            end
        end
        check({tag, "_lat"}, 32'(lat), exp_err ? 32'd1 : 32'd2);
        check({tag, "_err"}, 32'(got_err), 32'(exp_err));
        check({tag, "_rdata"}, got_rd, exp_rd);
        check({tag, "_we_cnt"}, 32'(we_seen),
              (we && !exp_err) ? 32'd1 : 32'd0);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(u_bus.resp_valid), 32'd0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ready"}, 32'(u_bus.req_ready), 32'd1);
        check({tag, "_rvalid"}, 32'(u_bus.resp_valid), 32'd0);
        check({tag, "_rdata"}, u_bus.resp_rdata, 32'd0);
        check({tag, "_rerr"}, 32'(u_bus.resp_err), 32'd0);
        check({tag, "_we"}, 32'(mem_WE), 32'd0);
        check({tag, "_sl"}, 32'(mem_SLType), 32'hF);
        check({tag, "_A"}, mem_A, 32'd0);
        check({tag, "_WD"}, mem_WD, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] w;
        int diffs;
        int resps;
        rst_n = 1'b0;
        u_bus.req_valid  = 1'b0;
        u_bus.req_we     = 1'b0;
        u_bus.req_funct3 = 3'd0;
        u_bus.req_addr   = 32'd0;
        u_bus.req_wdata  = 32'd0;
        repeat (2) @(negedge clk);
        check_reset_outs("rst");
        rst_n = 1'b1;

        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw10", rd);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, "lw10", rd);
        check("lw10_const", rd, 32'hDEADBEEF);

        do_req(1'b1, 3'd0, 32'h21, 32'h12345680, "sb21", rd);
        do_req(1'b0, 3'd0, 32'h21, 32'h0, "lb21", rd);
        check("lb21_const", rd, 32'hFFFFFF80);
        do_req(1'b0, 3'd4, 32'h21, 32'h0, "lbu21", rd);
        check("lbu21_const", rd, 32'h00000080);
        do_req(1'b0, 3'd1, 32'h20, 32'h0, "lh20", rd);
        do_req(1'b0, 3'd5, 32'h20, 32'h0, "lhu20", rd);

        do_req(1'b0, 3'd1, 32'h23, 32'h0, "lh_odd", rd);
        do_req(1'b1, 3'd2, 32'h102, 32'h55AA55AA, "sw_oor", rd);

        do_req(1'b1, 3'd2, 32'd252, 32'h8BADF00D, "sw252", rd);
        do_req(1'b0, 3'd2, 32'd252, 32'h0, "lw252", rd);
        check("lw252_const", rd, 32'h8BADF00D);
        do_req(1'b0, 3'd2, 32'd256, 32'h0, "lw256", rd);
        do_req(1'b1, 3'd1, 32'd254, 32'h0000C3C3, "sh254", rd);
        do_req(1'b0, 3'd1, 32'd254, 32'h0, "lh254", rd);
        do_req(1'b0, 3'd0, 32'd255, 32'h0, "lb255", rd);
        do_req(1'b0, 3'd0, 32'd256, 32'h0, "lb256", rd);
        do_req(1'b0, 3'd3, 32'h10, 32'h0, "f3_011", rd);
        do_req(1'b1, 3'd4, 32'h10, 32'h0, "sbu_ill", rd);
        do_req(1'b0, 3'd2, 32'hFFFFFFFC, 32'h0, "lw_wrap", rd);

        // Held request: accepted only every third cycle.
        @(negedge clk);
        u_bus.req_valid  = 1'b1;
        u_bus.req_we     = 1'b0;
        u_bus.req_funct3 = 3'd2;
        u_bus.req_addr   = 32'h10;
        resps = 0;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("b2b_ready%0d", i), 32'(u_bus.req_ready),
                  (i % 3 == 0) ? 32'd1 : 32'd0);
            if (u_bus.resp_valid) resps++;
            @(negedge clk);
        end
        u_bus.req_valid = 1'b0;
        check("b2b_resps", 32'(resps), 32'd3);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            case ($urandom % 4)
                0: a = 32'h80 + ($urandom % 128);
                1: a = 32'd248 + ($urandom % 12);
                2: a = 32'h80 + 4 * ($urandom % 32);
                default: a = $urandom;
            endcase
            w = $urandom;
            do_req(1'($urandom % 2), 3'($urandom % 8), a, w,
                   $sformatf("rnd%0d", i), rd);
        end

        // Reset during the store's access cycle must suppress the write.
        @(negedge clk);
        u_bus.req_valid  = 1'b1;
        u_bus.req_we     = 1'b1;
        u_bus.req_funct3 = 3'd2;
        u_bus.req_addr   = 32'h40;
        u_bus.req_wdata  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        u_bus.req_valid = 1'b0;
        #1;
        check("rstmid_we_before", 32'(mem_WE), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outs("rstmid");
        @(negedge clk);
        check_reset_outs("rstmid_hold");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b0, 3'd2, 32'h40, 32'h0, "lw40", rd);
        check("lw40_const", rd, 32'h0);

        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== shadow[i]) diffs++;
        check("mem_image", 32'(diffs), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the RISC-V execute stage and the 256-byte byte-addressed data memory. It accepts one memory request at a time over a valid/ready handshake and checks alignment, range and funct3. It drives the memory's address, write-data, write-enable and store-load-type inputs for exactly one cycle, then returns a registered, sign- or zero-extended load result or an error flag.

## Interface
Parameters:
- MEM_BYTES, 256: memory size in bytes; addresses at or above this are out of range.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 of the load/store
- req_addr  in  32  byte address (rs1 + imm, already computed)
- req_wdata  in  32  store data (rs2)
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal funct3; valid with resp_valid
- mem_A  out  32  memory address
- mem_WD  out  32  memory write data
- mem_WE  out  1  memory write enable
- mem_SLType  out  4  memory store-load type
- mem_RD  in  32  memory combinational read data

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register we/funct3/addr/wdata and compute error.
  - No error → ACCESS; error → RESP with err flag set. An erroring request never touches memory.
- ACCESS:
  - Drive mem_A=addr, mem_WD=wdata, mem_SLType from the decode, mem_WE=we.
  - For loads, capture the extended mem_RD into the response register.
  - → RESP.
- RESP:
  - resp_valid=1 for this single cycle; no backpressure.
  - → IDLE.
- req_ready=0 in ACCESS and RESP. Requests presented then are ignored; the requester holds them.
- SLType encoding:
  - Loads: 4'b0000 byte, 4'b0001 half, 4'b0010 word.
  - Stores: 4'b1000 byte, 4'b1001 half, 4'b1010 word.
  - Outside ACCESS: 4'b1111, which makes memory read 0. mem_WE=0.
- funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Every other combination is illegal → err.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0.
- Range: the whole access must satisfy addr + size ≤ MEM_BYTES.
  - Word at 252 is legal; word at 256 is err.
  - Half at 254 is legal.
  - Byte at 255 is legal; byte at 256 is err.
- Extension:
  - LB/LH replicate bit 7/15.
  - LBU/LHU zero-fill.
  - LW passes through.
  - Memory already zero-fills upper bytes, so only the sign replication is added.
- Stores pass full req_wdata; memory uses only the low bytes.
- resp_rdata=0 and resp_err=0 for successful stores.

## Timing
- Request accepted at edge k. mem_* are active during cycle k..k+1.
- Store writes memory at edge k+1. Load data is captured at edge k+1.
- resp_valid is high in cycle k+1..k+2.
- req_ready is high again in cycle k+2..k+3.
- Throughput: one access per 3 cycles. Error path: resp_valid in cycle k..k+1, one cycle sooner.
- Reset values: state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0; mem_WE=0; mem_SLType=4'b1111; mem_A=0; mem_WD=0.
- Reset asserted during ACCESS:
  - mem_WE drops immediately (asynchronous), so no write occurs.
  - The pending response is discarded.
- req_valid and reset release in the same cycle: the request is sampled at the first edge after deassertion.
- All outputs are registered or decoded from registered state only. No combinational path from req_* to mem_*.

## Structure
- lsu_pkg:
  - State enum {IDLE, ACCESS, RESP}.
  - SLType localparams (SL_LB, SL_LH, SL_LW, SL_SB, SL_SH, SL_SW, SL_NONE).
  - funct3 localparams.
  - Function access_size(funct3).
- Sub-module lsu_extend: combinational (funct3, raw[31:0]) → extended data. Instantiated once inside load_store_unit.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → store resp_err=0; load resp_rdata=0xDEADBEEF, resp_valid exactly 2 cycles after acceptance.
- SB 0x80 @0x21; LB @0x21 → 0xFFFFFF80; LBU @0x21 → 0x00000080.
- LH @0x23 (odd) and SW @0x102 → resp_err=1 one cycle after acceptance; mem_WE never asserted; memory unchanged.
- LW @252 → legal read of bytes 252..255; LW @256 → resp_err=1.
- funct3=3'b011 load → resp_err=1. Back-to-back req_valid held high → accepted only every 3rd cycle; req_ready=0 in between.
- Assert rst_n low mid-ACCESS of SW @0x40 → no write (LW @0x40 afterwards reads 0); outputs at reset values while rst_n=0.
